// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
//
// Shared definitions for the 7-segment scan multiplexer:
//   SEG_W      - width of one digit's segment pattern (a..g)
//   SEG_BLANK  - logical "all segments off" pattern, before output polarity
//   scan_state_t - scan FSM states (IDLE, BLANK, SHOW)
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// ----------------------------------------------------------------------------
// scan_prescaler
//
// Slot counter for the digit scan. Counts 0..PRESCALE-1 and wraps; held at
// zero while clear is high.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high
//   clear      - hold the counter at 0 (scanning stopped / about to start)
//   blank_end  - count is on the last guard cycle (BLANK_CYCLES-1)
//   slot_end   - count is on the last cycle of the slot (PRESCALE-1)
// ----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || slot_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Strobes are decoded from the registered count so the FSM sees them
    // during the cycle that the count sits on the boundary value.
    assign blank_end = (count == BLANK_LAST);
    assign slot_end  = (count == SLOT_LAST);

endmodule

// File: rtl/seg7_scan_mux.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed driver for a DIGITS-digit 7-segment display. Segment
// patterns from the per-digit decoders are captured into a staging register,
// moved into a shadow (displayed) register only in IDLE or at a frame
// boundary, and scanned one digit per PRESCALE-clock slot. Each slot starts
// with BLANK_CYCLES dark clocks to suppress ghosting between digits.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high
//   enable     - scanning runs while high
//   load       - capture seg_in into staging this cycle
//   seg_in     - DIGITS*7 bits, digit k at [7k+6:7k], 1 = segment lit
//   seg_out    - shared segment bus (inverted when ACTIVE_LOW != 0)
//   digit_en   - one-hot digit select, active-high, all zero while dark
//   frame_done - one-cycle pulse when the last digit slot completes
//   pending    - staging holds data not yet transferred to shadow
// ----------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [DIGITS*SEG_W-1:0] seg_in,
    output logic [SEG_W-1:0]        seg_out,
    output logic [DIGITS-1:0]       digit_en,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Apply board polarity to a logical (1 = lit) pattern.
    function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] pat);
        seg_drive = (ACTIVE_LOW != 0) ? ~pat : pat;
    endfunction

    scan_state_t               state;
    logic [IDX_W-1:0]          idx;
    logic [DIGITS*SEG_W-1:0]   staging;
    logic [DIGITS*SEG_W-1:0]   shadow;

    logic                      presc_clear;
    logic                      blank_end;
    logic                      slot_end;
    logic                      frame_end;
    logic                      transfer;
    logic [SEG_W-1:0]          cur_pat;

    // The counter is held at zero while stopped so that the first slot after
    // IDLE->BLANK begins with a full guard interval.
    assign presc_clear = !enable || (state == IDLE);

    scan_prescaler #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_presc (
        .clock     (clock),
        .reset     (reset),
        .clear     (presc_clear),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    // Last SHOW cycle of the last digit: the frame boundary.
    assign frame_end = (state == SHOW) && slot_end && (idx == IDX_LAST);

    // Shadow is only rewritten when nothing is being displayed mid-frame,
    // so a frame never mixes old and new patterns.
    assign transfer = pending && ((state == IDLE) || frame_end);

    assign cur_pat = shadow[32'(idx)*SEG_W +: SEG_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            staging    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            seg_out    <= seg_drive(SEG_BLANK);
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            // Load path: a load on the same cycle as a transfer wins the
            // pending flag, so that data waits for the next boundary.
            if (transfer) begin
                shadow  <= staging;
                pending <= 1'b0;
            end
            if (load) begin
                staging <= seg_in;
                pending <= 1'b1;
            end

            // Scan FSM
            if (!enable) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        idx   <= '0;
                    end
                    BLANK: begin
                        if (blank_end) begin
                            state <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (slot_end) begin
                            state <= BLANK;
                            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                endcase
            end

            // Registered outputs. Gating with enable blanks the display on
            // the very next clock after enable drops, even mid-SHOW.
            if (enable && (state == SHOW)) begin
                digit_en <= DIGITS'(1) << idx;
                seg_out  <= seg_drive(cur_pat);
            end else begin
                digit_en <= '0;
                seg_out  <= seg_drive(SEG_BLANK);
            end

            frame_done <= enable && frame_end;
        end
    end

endmodule
